// File: rtl/nv_nvdla_bdma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_bdma_pkg
//  Description : Shared BDMA definitions for the register-group scheduler:
//                group count, group-id type, launch FSM encoding and a
//                group-id to one-hot helper.
//  Revision    : 1.0  initial release
// ============================================================================
package nv_nvdla_bdma_pkg;

    // Number of CSB register groups (ping-pong pair).
    localparam int BDMA_GRP_NUM = 2;

    // Group identifier: one bit selects grp0 / grp1.
    typedef logic bdma_grp_t;

    // Per-group bit vector (op_en, launched, interrupt lines).
    typedef logic [BDMA_GRP_NUM-1:0] bdma_grp_vec_t;

    // Launch FSM encoding.
    typedef logic [0:0] bdma_ld_state_t;
    localparam bdma_ld_state_t LD_IDLE = 1'b0;
    localparam bdma_ld_state_t LD_REQ  = 1'b1;

    // One-hot mask selecting a single group.
    function automatic bdma_grp_vec_t grp_onehot(input bdma_grp_t g);
        bdma_grp_vec_t m;
        m    = '0;
        m[g] = 1'b1;
        return m;
    endfunction

endpackage : nv_nvdla_bdma_pkg
`default_nettype wire

// File: rtl/nv_nvdla_bdma_grp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_bdma_grp_sched
//  Description : Ping-pong register-group scheduler for BDMA. Tracks op_en of
//                the two CSB groups, launches them to the load engine in
//                strict alternating order and retires them on store-done,
//                raising a per-group completion interrupt pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module nv_nvdla_bdma_grp_sched
    import nv_nvdla_bdma_pkg::*;
(
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic [BDMA_GRP_NUM-1:0] reg2sched_op_en_set,
    input  logic [BDMA_GRP_NUM-1:0] reg2sched_intr_en,
    output logic                    sched2ld_vld,
    input  logic                    ld2sched_rdy,
    output logic                    sched2ld_grp,
    input  logic                    st2sched_done,
    input  logic                    st2sched_done_grp,
    output logic [BDMA_GRP_NUM-1:0] sched2reg_op_en,
    output logic                    sched2reg_lp,
    output logic                    sched2reg_dp,
    output logic [BDMA_GRP_NUM-1:0] sched2glb_done_intr_pd,
    output logic                    sched2reg_err,
    output logic                    sched_idle
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    bdma_ld_state_t r_state;
    logic           r_vld;
    bdma_grp_t      r_grp;
    bdma_grp_t      r_lp;
    bdma_grp_t      r_dp;
    bdma_grp_vec_t  r_op_en;
    bdma_grp_vec_t  r_launched;
    bdma_grp_vec_t  r_intr_pd;
    logic           r_err;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic          w_launch_ok;
    logic          w_accept;
    logic          w_retire;
    logic          w_done_bad;
    bdma_grp_vec_t w_ret_mask;
    bdma_grp_vec_t w_lch_mask;
    bdma_grp_vec_t w_op_en_nxt;
    bdma_grp_vec_t w_launched_nxt;

    // The group at the launch pointer is ready when armed and not yet sent.
    assign w_launch_ok = r_op_en[r_lp] & ~r_launched[r_lp];

    // Handshake completes only while a request is outstanding.
    assign w_accept    = (r_state == LD_REQ) & ld2sched_rdy;

    // A done is legal only for the oldest in-flight group.
    assign w_retire    = st2sched_done & (st2sched_done_grp == r_dp) & r_launched[r_dp];
    assign w_done_bad  = st2sched_done & ~w_retire;

    assign w_ret_mask  = w_retire ? grp_onehot(r_dp)  : '0;
    assign w_lch_mask  = w_accept ? grp_onehot(r_grp) : '0;

    // Retire clears first, then a same-cycle set re-arms the group; a set on
    // an already armed group leaves it untouched (launched is not affected).
    assign w_op_en_nxt    = (r_op_en & ~w_ret_mask) | reg2sched_op_en_set;
    assign w_launched_nxt = (r_launched & ~w_ret_mask) | w_lch_mask;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Launch FSM: registered request, held stable until accepted, then one
    // idle cycle before the next group can be requested.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= LD_IDLE;
            r_vld   <= 1'b0;
            r_grp   <= 1'b0;
            r_lp    <= 1'b0;
        end else begin
            case (r_state)
                LD_IDLE: begin
                    if (w_launch_ok) begin
                        r_state <= LD_REQ;
                        r_vld   <= 1'b1;
                        r_grp   <= r_lp;
                    end
                end
                LD_REQ: begin
                    if (ld2sched_rdy) begin
                        r_state <= LD_IDLE;
                        r_vld   <= 1'b0;
                        r_lp    <= ~r_lp;
                    end
                end
                default: begin
                    r_state <= LD_IDLE;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    // Per-group op_en / launched bookkeeping.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_op_en    <= '0;
            r_launched <= '0;
        end else begin
            r_op_en    <= w_op_en_nxt;
            r_launched <= w_launched_nxt;
        end
    end

    // Retire path: done pointer, one-cycle interrupt pulse, sticky error.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_dp      <= 1'b0;
            r_intr_pd <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_retire) begin
                r_dp <= ~r_dp;
            end
            r_intr_pd <= w_ret_mask & reg2sched_intr_en;
            r_err     <= r_err | w_done_bad;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sched2ld_vld           = r_vld;
    assign sched2ld_grp           = r_grp;
    assign sched2reg_op_en        = r_op_en;
    assign sched2reg_lp           = r_lp;
    assign sched2reg_dp           = r_dp;
    assign sched2glb_done_intr_pd = r_intr_pd;
    assign sched2reg_err          = r_err;
    assign sched_idle             = (r_op_en == '0) & ~r_vld;

endmodule : nv_nvdla_bdma_grp_sched
`default_nettype wire
